// File: rtl/vector_types_pkg.sv
// Shared types and helpers for the vector micro-op sequencer.
//   sew_t       : element width encoding (8/16/32/64 bits)
//   vlmul_t     : register group multiplier encoding (1/2/4/8)
//   seq_state_t : sequencer FSM state
//   epr_shift   : log2 of elements-per-register for a given VLEN, SEW and widening
//   lmul_log2   : log2 of the register group size, fractional settings collapse to 1
package vector_types_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_t;

    typedef enum logic [2:0] {
        LMUL1 = 3'd0,
        LMUL2 = 3'd1,
        LMUL4 = 3'd2,
        LMUL8 = 3'd3
    } vlmul_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    // Elements per register is VLEN / (SEW * (widen ? 2 : 1)); return its log2.
    // A 2*SEW64 operand on a 64-bit VLEN would be below one element per
    // register, so the shift saturates at zero instead of going negative.
    function automatic logic [3:0] epr_shift(input int vlen_log2, input sew_t sew,
                                             input logic widen);
        int s;
        s = vlen_log2 - 3 - int'(sew) - int'(widen);
        if (s < 0) begin
            return 4'd0;
        end else begin
            return 4'(s);
        end
    endfunction

    // Encodings 4..7 are fractional LMUL, which still occupy one register.
    function automatic logic [1:0] lmul_log2(input logic [2:0] lmul);
        if (lmul[2]) begin
            return 2'd0;
        end else begin
            return lmul[1:0];
        end
    endfunction

endpackage

// File: rtl/vreg_offset_calc.sv
// Register index calculator for one vector operand.
//   base      in  5     first register of the operand's group
//   elem      in  VL_W  element index of lane 0 of the current uop
//   sew       in  2     element width of the op
//   widen     in  1     operand is held at 2*SEW
//   lmul_log2 in  2     log2 of the group size at SEW
//   idx       out 5     register holding element 'elem'
//   ovf       out 1     group (base .. base+span-1) runs past register 31
module vreg_offset_calc
    import vector_types_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int VL_W = $clog2(VLEN + 1)
) (
    input  logic [4:0]      base,
    input  logic [VL_W-1:0] elem,
    input  sew_t            sew,
    input  logic            widen,
    input  logic [1:0]      lmul_log2,
    output logic [4:0]      idx,
    output logic            ovf
);

    localparam int VLEN_LOG2 = $clog2(VLEN);

    logic [3:0] shift_s;
    logic [2:0] span_log2_s;
    logic [5:0] span_s;

    // Register offset within the group and group-overflow detection.
    // A widened operand spans twice as many registers as its LMUL setting.
    always_comb begin
        shift_s     = epr_shift(VLEN_LOG2, sew, widen);
        idx         = base + 5'(elem >> shift_s);
        span_log2_s = {1'b0, lmul_log2} + {2'b00, widen};
        span_s      = 6'd1 << span_log2_s;
        ovf         = ({1'b0, base} + span_s) > 6'd32;
    end

endmodule

// File: rtl/vector_uop_sequencer.sv
// Expands one decoded vector op into per-cycle micro-ops of LANES elements.
//   CLK, RST                 clock, synchronous active-high reset
//   op_valid/op_ready        decoded-op handshake (ready only in IDLE)
//   op_vs1/vs2/vd            base register indices
//   op_sew, op_lmul          element width, register group multiplier
//   op_vl, op_vstart         active length and first element
//   op_vd_widen, op_vs2_widen, op_vd_narrow, op_reduction   operand shape
//   flush                    abandon the current sequence
//   uop_valid/uop_ready      micro-op handshake
//   uop_vs1/vs2/vd, uop_elem, uop_lane_en, uop_first, uop_last   micro-op fields
//   op_done                  pulse when an op has fully issued (or was empty)
//   illegal                  pulse when an op's register group overflows
//   busy                     sequencer is issuing
module vector_uop_sequencer
    import vector_types_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int LANES = 2,
    parameter int VL_W  = $clog2(VLEN + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [4:0]       op_vs1,
    input  logic [4:0]       op_vs2,
    input  logic [4:0]       op_vd,
    input  logic [1:0]       op_sew,
    input  logic [2:0]       op_lmul,
    input  logic [VL_W-1:0]  op_vl,
    input  logic [VL_W-1:0]  op_vstart,
    input  logic             op_vd_widen,
    input  logic             op_vs2_widen,
    input  logic             op_vd_narrow,
    input  logic             op_reduction,
    input  logic             flush,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [4:0]       uop_vs1,
    output logic [4:0]       uop_vs2,
    output logic [4:0]       uop_vd,
    output logic [VL_W-1:0]  uop_elem,
    output logic [LANES-1:0] uop_lane_en,
    output logic             uop_first,
    output logic             uop_last,
    output logic             op_done,
    output logic             illegal,
    output logic             busy
);

    localparam logic [VL_W-1:0] LANE_MASK = VL_W'(LANES - 1);
    localparam logic [VL_W-1:0] LANES_W   = VL_W'(LANES);

    seq_state_t state_r, state_n_s;

    // Operand fields captured when an op starts issuing
    logic [4:0]      vs1_r, vs2_r, vd_r;
    sew_t            sew_r;
    logic [VL_W-1:0] vl_r, vstart_r;
    logic            vd_widen_r, vs2_wide_r, red_r;

    // Operand source: live op inputs while IDLE, captured copy while ISSUE
    logic            idle_s;
    logic [4:0]      src_vs1_s, src_vs2_s, src_vd_s;
    sew_t            src_sew_s;
    logic [VL_W-1:0] src_vl_s, src_vstart_s;
    logic            src_vd_widen_s, src_vs2_wide_s, src_red_s;

    logic [VL_W-1:0]  elem_n_s;
    logic [LANES-1:0] lane_en_n_s;
    logic             first_n_s, last_n_s, load_s, done_n_s, illegal_n_s;
    logic [4:0]       vs1_idx_s, vs2_idx_s, vd_idx_s;
    logic             vs1_ovf_s, vs2_ovf_s, vd_ovf_s, ovf_s;
    logic [1:0]       lmul_log2_s;

    assign idle_s   = (state_r == IDLE);
    assign op_ready = idle_s;
    assign busy     = ~idle_s;

    // Select where the next uop's operand description comes from.
    always_comb begin
        if (idle_s) begin
            src_vs1_s      = op_vs1;
            src_vs2_s      = op_vs2;
            src_vd_s       = op_vd;
            src_sew_s      = sew_t'(op_sew);
            src_vl_s       = op_vl;
            src_vstart_s   = op_vstart;
            src_vd_widen_s = op_vd_widen;
            src_vs2_wide_s = op_vs2_widen | op_vd_narrow;
            src_red_s      = op_reduction;
        end else begin
            src_vs1_s      = vs1_r;
            src_vs2_s      = vs2_r;
            src_vd_s       = vd_r;
            src_sew_s      = sew_r;
            src_vl_s       = vl_r;
            src_vstart_s   = vstart_r;
            src_vd_widen_s = vd_widen_r;
            src_vs2_wide_s = vs2_wide_r;
            src_red_s      = red_r;
        end
    end

    assign lmul_log2_s = lmul_log2(op_lmul);

    vreg_offset_calc #(.VLEN(VLEN), .VL_W(VL_W)) u_vs1_calc (
        .base(src_vs1_s), .elem(elem_n_s), .sew(src_sew_s), .widen(1'b0),
        .lmul_log2(lmul_log2_s), .idx(vs1_idx_s), .ovf(vs1_ovf_s)
    );

    vreg_offset_calc #(.VLEN(VLEN), .VL_W(VL_W)) u_vs2_calc (
        .base(src_vs2_s), .elem(elem_n_s), .sew(src_sew_s), .widen(src_vs2_wide_s),
        .lmul_log2(lmul_log2_s), .idx(vs2_idx_s), .ovf(vs2_ovf_s)
    );

    vreg_offset_calc #(.VLEN(VLEN), .VL_W(VL_W)) u_vd_calc (
        .base(src_vd_s), .elem(elem_n_s), .sew(src_sew_s), .widen(src_vd_widen_s),
        .lmul_log2(lmul_log2_s), .idx(vd_idx_s), .ovf(vd_ovf_s)
    );

    // Reductions keep vs1/vd on a single register, so only vs2 can overflow.
    assign ovf_s = vs2_ovf_s | (~src_red_s & (vs1_ovf_s | vd_ovf_s));

    // Next-state, next element and pulse generation.
    always_comb begin
        state_n_s   = state_r;
        elem_n_s    = uop_elem;
        first_n_s   = 1'b0;
        load_s      = 1'b0;
        done_n_s    = 1'b0;
        illegal_n_s = 1'b0;
        if (flush) begin
            state_n_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_valid) begin
                        if (op_vstart >= op_vl) begin
                            done_n_s = 1'b1;
                        end else if (ovf_s) begin
                            illegal_n_s = 1'b1;
                        end else begin
                            state_n_s = ISSUE;
                            elem_n_s  = op_vstart & ~LANE_MASK;
                            first_n_s = 1'b1;
                            load_s    = 1'b1;
                        end
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (uop_ready) begin
                        if (uop_last) begin
                            state_n_s = IDLE;
                            done_n_s  = 1'b1;
                        end else begin
                            elem_n_s = uop_elem + LANES_W;
                            load_s   = 1'b1;
                        end
                    end else begin
                        state_n_s = ISSUE;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end
    end

    // Lane enables and last flag for the uop about to be loaded.
    always_comb begin
        lane_en_n_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_en_n_s[i] = (({1'b0, elem_n_s} + (VL_W + 1)'(i)) >= {1'b0, src_vstart_s}) &&
                             (({1'b0, elem_n_s} + (VL_W + 1)'(i)) <  {1'b0, src_vl_s});
        end
        last_n_s = ({1'b0, elem_n_s} + (VL_W + 1)'(LANES)) >= {1'b0, src_vl_s};
    end

    // FSM state, pulses and registered uop outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            op_done     <= 1'b0;
            illegal     <= 1'b0;
            uop_valid   <= 1'b0;
            uop_vs1     <= 5'd0;
            uop_vs2     <= 5'd0;
            uop_vd      <= 5'd0;
            uop_elem    <= '0;
            uop_lane_en <= '0;
            uop_first   <= 1'b0;
            uop_last    <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            op_done   <= done_n_s;
            illegal   <= illegal_n_s;
            uop_valid <= (state_n_s == ISSUE);
            if (state_n_s != ISSUE) begin
                uop_vs1     <= 5'd0;
                uop_vs2     <= 5'd0;
                uop_vd      <= 5'd0;
                uop_elem    <= '0;
                uop_lane_en <= '0;
                uop_first   <= 1'b0;
                uop_last    <= 1'b0;
            end else if (load_s) begin
                uop_vs1     <= src_red_s ? src_vs1_s : vs1_idx_s;
                uop_vs2     <= vs2_idx_s;
                uop_vd      <= src_red_s ? src_vd_s : vd_idx_s;
                uop_elem    <= elem_n_s;
                uop_lane_en <= lane_en_n_s;
                uop_first   <= first_n_s;
                uop_last    <= last_n_s;
            end
        end
    end

    // Capture the op description when it starts issuing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vs1_r      <= 5'd0;
            vs2_r      <= 5'd0;
            vd_r       <= 5'd0;
            sew_r      <= SEW8;
            vl_r       <= '0;
            vstart_r   <= '0;
            vd_widen_r <= 1'b0;
            vs2_wide_r <= 1'b0;
            red_r      <= 1'b0;
        end else if (load_s && idle_s) begin
            vs1_r      <= src_vs1_s;
            vs2_r      <= src_vs2_s;
            vd_r       <= src_vd_s;
            sew_r      <= src_sew_s;
            vl_r       <= src_vl_s;
            vstart_r   <= src_vstart_s;
            vd_widen_r <= src_vd_widen_s;
            vs2_wide_r <= src_vs2_wide_s;
            red_r      <= src_red_s;
        end
    end

endmodule
